sram_axi_read_slave: RTL and testbench

- AXI-style read-only slave that serves the debug bridge's read address (AR) and read data (R) channels from an external asynchronous 16-bit SRAM (18-bit word address, 256K x 16).
- Sits directly downstream of the UART debug master: consumes its AR requests and produces its R beats.
- The SRAM bidirectional DQ tri-state is resolved at the top level; this block only reads DQ and never drives it.

---
 rtl/sram_rd_pkg.sv | 13 +
 rtl/sram_axi_read_slave.sv | 155 +++++++++++++++
 tb/tb_sram_axi_read_slave.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_rd_pkg.sv
// Shared widths, FSM state type and wait-counter width for the SRAM read slave
// and the debug master that drives it.
package sram_rd_pkg;
   localparam int unsigned ADDR_W = 18;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;
endpackage

// File: rtl/sram_axi_read_slave.sv
// AXI-style read-only slave serving AR/R from an asynchronous 16-bit SRAM.
// Optional last-address hit register enabled by defining SRAM_LAST_HIT_EN.
module sram_axi_read_slave #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned ADDR_W      = sram_rd_pkg::ADDR_W,
   parameter int unsigned DATA_W      = sram_rd_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] axi_ar_addr,
   input  logic              axi_ar_valid,
   output logic              axi_ar_ready,
   output logic [DATA_W-1:0] axi_r_data,
   output logic              axi_r_valid,
   input  logic              axi_r_ready,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic [DATA_W-1:0] sram_dq_in,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_lb_n,
   output logic              sram_ub_n,
   input  logic              cache_inval
);
   import sram_rd_pkg::*;

   state_t            r_state, w_state_nx;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
   logic              r_ar_ready, w_ar_ready_nx;
   logic              r_r_valid, w_r_valid_nx;
   logic [DATA_W-1:0] r_r_data, w_r_data_nx;
   logic [ADDR_W-1:0] r_sram_addr, w_sram_addr_nx;
   logic              r_en_n, w_en_n_nx;
   logic              w_ar_hs;
   logic              w_sample;
   logic              w_hit;
   logic [DATA_W-1:0] w_last_data;

   assign w_ar_hs = r_ar_ready && axi_ar_valid;

`ifdef SRAM_LAST_HIT_EN
   logic [ADDR_W-1:0] r_last_addr;
   logic [DATA_W-1:0] r_last_data;
   logic              r_last_valid;

   // An invalidate arriving with the handshake forces a real SRAM access.
   assign w_hit       = r_last_valid && !cache_inval && (axi_ar_addr == r_last_addr);
   assign w_last_data = r_last_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last_valid <= 1'b0;
         r_last_addr  <= '0;
         r_last_data  <= '0;
      end else begin
         if (w_sample) begin
            r_last_addr <= r_sram_addr;
            r_last_data <= sram_dq_in;
         end
         if (cache_inval)
            r_last_valid <= 1'b0;
         else if (w_sample)
            r_last_valid <= 1'b1;
      end
   end
`else
   logic w_unused_inval;
   assign w_unused_inval = cache_inval;
   assign w_hit          = 1'b0;
   assign w_last_data    = '0;
`endif

   always_comb begin
      w_state_nx     = r_state;
      w_cnt_nx       = r_cnt;
      w_ar_ready_nx  = r_ar_ready;
      w_r_valid_nx   = r_r_valid;
      w_r_data_nx    = r_r_data;
      w_sram_addr_nx = r_sram_addr;
      w_en_n_nx      = r_en_n;
      w_sample       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_ar_hs) begin
               w_ar_ready_nx = 1'b0;
               if (w_hit) begin
                  w_r_data_nx  = w_last_data;
                  w_r_valid_nx = 1'b1;
                  w_state_nx   = RESP;
               end else begin
                  w_sram_addr_nx = axi_ar_addr;
                  w_en_n_nx      = 1'b0;
                  w_cnt_nx       = CNT_W'(WAIT_CYCLES - 1);
                  w_state_nx     = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (r_cnt != '0) begin
               w_cnt_nx = r_cnt - CNT_W'(1);
            end else begin
               w_sample     = 1'b1;
               w_r_data_nx  = sram_dq_in;
               w_r_valid_nx = 1'b1;
               w_en_n_nx    = 1'b1;
               w_state_nx   = RESP;
            end
         end
         RESP: begin
            if (axi_r_ready) begin
               w_r_valid_nx  = 1'b0;
               w_ar_ready_nx = 1'b1;
               w_state_nx    = IDLE;
            end
         end
         default: begin
            w_state_nx    = IDLE;
            w_ar_ready_nx = 1'b1;
            w_r_valid_nx  = 1'b0;
            w_en_n_nx     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_ar_ready  <= 1'b1;
         r_r_valid   <= 1'b0;
         r_r_data    <= '0;
         r_sram_addr <= '0;
         r_en_n      <= 1'b1;
      end else begin
         r_state     <= w_state_nx;
         r_cnt       <= w_cnt_nx;
         r_ar_ready  <= w_ar_ready_nx;
         r_r_valid   <= w_r_valid_nx;
         r_r_data    <= w_r_data_nx;
         r_sram_addr <= w_sram_addr_nx;
         r_en_n      <= w_en_n_nx;
      end
   end

   assign axi_ar_ready = r_ar_ready;
   assign axi_r_valid  = r_r_valid;
   assign axi_r_data   = r_r_data;
   assign sram_addr    = r_sram_addr;
   assign sram_ce_n    = r_en_n;
   assign sram_oe_n    = r_en_n;
   assign sram_lb_n    = r_en_n;
   assign sram_ub_n    = r_en_n;
   assign sram_we_n    = 1'b1;

endmodule

// File: tb/tb_sram_axi_read_slave.sv
// Bench for sram_axi_read_slave: three instances (WAIT_CYCLES 2, 1, 15) against
// an SRAM array model and a last-hit prediction kept at transaction level.
module tb_sram_axi_read_slave;
   localparam int NI = 3;

   logic        clk;
   logic        rst_n;
   logic [17:0] ar_addr  [NI];
   logic        ar_valid [NI];
   logic        ar_ready [NI];
   logic [15:0] r_data   [NI];
   logic        r_valid  [NI];
   logic        r_ready  [NI];
   logic [17:0] s_addr   [NI];
   logic [15:0] dq       [NI];
   logic        ce_n [NI], oe_n [NI], we_n [NI], lb_n [NI], ub_n [NI];
   logic        inval    [NI];

   logic [15:0] mem [0:262143];

   int checks = 0;
   int errors = 0;

   bit          lv [NI];
   logic [17:0] la [NI];

   typedef struct {
      int          k;
      logic [17:0] addr;
      int          stall;
      logic [15:0] data;
   } vec_t;
   vec_t tbl [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      sram_axi_read_slave #(
         .WAIT_CYCLES((g == 0) ? 2 : (g == 1) ? 1 : 15),
         .ADDR_W(18),
         .DATA_W(16)
      ) u_dut (
         .clk(clk),
         .rst_n(rst_n),
         .axi_ar_addr(ar_addr[g]),
         .axi_ar_valid(ar_valid[g]),
         .axi_ar_ready(ar_ready[g]),
         .axi_r_data(r_data[g]),
         .axi_r_valid(r_valid[g]),
         .axi_r_ready(r_ready[g]),
         .sram_addr(s_addr[g]),
         .sram_dq_in(dq[g]),
         .sram_ce_n(ce_n[g]),
         .sram_oe_n(oe_n[g]),
         .sram_we_n(we_n[g]),
         .sram_lb_n(lb_n[g]),
         .sram_ub_n(ub_n[g]),
         .cache_inval(inval[g])
      );
      assign dq[g] = !oe_n[g] ? mem[s_addr[g]] : 16'hBAD0;
   end

   function automatic int wc(input int k);
      return (k == 0) ? 2 : (k == 1) ? 1 : 15;
   endfunction

   function automatic bit pred_hit(input int k, input logic [17:0] addr);
`ifdef SRAM_LAST_HIT_EN
      return lv[k] && (la[k] == addr);
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Full read transaction; caller and task both sit at a negedge.
   task automatic do_read(input int k, input logic [17:0] addr, input int stall,
                          input logic [15:0] exp_data);
      int w, n, en_cnt, wait_cnt;
      bit hit;
      hit = pred_hit(k, addr);
      w = wc(k);
      r_ready[k] = (stall == 0);
      ar_addr[k] = addr;
      ar_valid[k] = 1'b1;
      wait_cnt = 0;
      while (!ar_ready[k] && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      chk("ar_wait", wait_cnt, 0);
      @(negedge clk);
      ar_valid[k] = 1'b0;
      n = 1;
      en_cnt = 0;
      while (!r_valid[k] && n < 40) begin
         if (n == 1) chk("sram_addr", s_addr[k], addr);
         if ({ce_n[k], oe_n[k], lb_n[k], ub_n[k]} == 4'h0) en_cnt++;
         @(negedge clk);
         n++;
      end
      chk("r_latency", n, hit ? 1 : w + 1);
      chk("en_cycles", en_cnt, hit ? 0 : w);
      chk("r_data", r_data[k], exp_data);
      chk("en_off", {ce_n[k], oe_n[k], lb_n[k], ub_n[k], we_n[k]}, 5'h1F);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk("stall_valid", r_valid[k], 1);
         chk("stall_data", r_data[k], exp_data);
         chk("stall_arrdy", ar_ready[k], 0);
      end
      r_ready[k] = 1'b1;
      @(negedge clk);
      chk("r_done_valid", r_valid[k], 0);
      chk("r_done_arrdy", ar_ready[k], 1);
      if (stall > 0) r_ready[k] = 1'b0;
      if (!hit) begin
         lv[k] = 1'b1;
         la[k] = addr;
      end
   endtask

   task automatic pulse_inval(input int k);
      inval[k] = 1'b1;
      @(negedge clk);
      inval[k] = 1'b0;
      lv[k] = 1'b0;
   endtask

   task automatic reset_mid(input int k, input int cyc);
      int beats, wait_cnt;
      r_ready[k] = 1'b0;
      ar_addr[k] = 18'h00777;
      ar_valid[k] = 1'b1;
      wait_cnt = 0;
      while (!ar_ready[k] && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      @(negedge clk);
      ar_valid[k] = 1'b0;
      repeat (cyc) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_en_n", {ce_n[k], oe_n[k], lb_n[k], ub_n[k]}, 4'hF);
      chk("rst_r_valid", r_valid[k], 0);
      chk("rst_ar_ready", ar_ready[k], 1);
      rst_n = 1'b1;
      for (int i = 0; i < NI; i++) lv[i] = 1'b0;
      r_ready[k] = 1'b1;
      beats = 0;
      repeat (20) begin
         @(negedge clk);
         if (r_valid[k]) beats++;
      end
      chk("no_r_beat", beats, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [17:0] prev [NI];
      for (int i = 0; i < 262144; i++) mem[i] = 16'($urandom);
      mem[18'h00123] = 16'hBEEF;
      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) begin
         ar_addr[i] = '0; ar_valid[i] = 1'b0; r_ready[i] = 1'b0; inval[i] = 1'b0;
         lv[i] = 1'b0; la[i] = '0; prev[i] = 18'h00042;
      end

      tbl[0] = '{0, 18'h00123, 10, 16'hBEEF};
      tbl[1] = '{0, 18'h3FFFF, 0, mem[18'h3FFFF]};
      tbl[2] = '{0, 18'h00000, 0, mem[18'h00000]};
      tbl[3] = '{1, 18'h00123, 0, 16'hBEEF};
      tbl[4] = '{1, 18'h2AAAA, 2, mem[18'h2AAAA]};
      tbl[5] = '{2, 18'h00123, 0, 16'hBEEF};
      tbl[6] = '{2, 18'h15555, 1, mem[18'h15555]};
      tbl[7] = '{0, 18'h00042, 0, mem[18'h00042]};

      repeat (4) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk("rst_ar_ready", ar_ready[i], 1);
         chk("rst_r_valid", r_valid[i], 0);
         chk("rst_r_data", r_data[i], 0);
         chk("rst_sram_addr", s_addr[i], 0);
         chk("rst_strobes", {ce_n[i], oe_n[i], lb_n[i], ub_n[i], we_n[i]}, 5'h1F);
      end
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) do_read(tbl[i].k, tbl[i].addr, tbl[i].stall, tbl[i].data);

      // repeat read: served from the last-hit register when that feature is built
      do_read(0, 18'h00042, 0, mem[18'h00042]);
      pulse_inval(0);
      do_read(0, 18'h00042, 0, mem[18'h00042]);

      reset_mid(0, 0);
      do_read(0, 18'h00010, 0, mem[18'h00010]);
      reset_mid(2, 18);
      do_read(2, 18'h00010, 0, mem[18'h00010]);

      for (int it = 0; it < 40; it++) begin
         int k;
         logic [17:0] a;
         k = int'($urandom_range(0, NI - 1));
         a = ($urandom_range(0, 2) == 0) ? prev[k] : 18'($urandom);
         if ($urandom_range(0, 7) == 0) pulse_inval(k);
         do_read(k, a, int'($urandom_range(0, 3)), mem[a]);
         prev[k] = a;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
